// File: rtl/noc2node_reply_filter_pkg.sv
// Shared NIC widths, coherence message encodings, FSM state type and the
// reply-to-request type mapping used by both NIC directions.
package noc2node_reply_filter_pkg;

    localparam int BUS_ADDRESS_WIDTH             = 8;
    localparam int N_BITS_COHERENCE_MESSAGE_TYPE = 4;

    typedef logic [N_BITS_COHERENCE_MESSAGE_TYPE-1:0] msg_type_t;

    // Requests occupy the lower half of the type space; each reply is its
    // request code with the top bit set.
    localparam msg_type_t REQ_A   = 4'h1;
    localparam msg_type_t REQ_B   = 4'h2;
    localparam msg_type_t REPLY_A = 4'h9;
    localparam msg_type_t REPLY_B = 4'hA;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOOKUP  = 2'd1,
        ST_FORWARD = 2'd2,
        ST_DROP    = 2'd3
    } state_t;

    function automatic msg_type_t reply2request(input msg_type_t reply_type);
        return {1'b0, reply_type[N_BITS_COHERENCE_MESSAGE_TYPE-2:0]};
    endfunction

endpackage

// File: rtl/noc2node_reply_filter.sv
// Filters NoC replies against the parent's pending-transaction table:
// matched replies retire their entry and go to the local master, others are dropped.
//
// state   | meaning
// IDLE    | ready for a reply; capture all in_* fields on handshake
// LOOKUP  | one-cycle table query; hit retires the entry
// FORWARD | hold captured reply on out_* until the master accepts it
// DROP    | unmatched reply: one unexpected pulse, bump saturating counter
module noc2node_reply_filter
    import noc2node_reply_filter_pkg::*;
#(
    parameter int PAYLOAD_WIDTH  = 32,
    parameter int DROP_CNT_WIDTH = 8
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     in_valid_i,
    output logic                                     in_ready_o,
    input  logic [BUS_ADDRESS_WIDTH-1:0]             in_sender_i,
    input  logic [BUS_ADDRESS_WIDTH-1:0]             in_recipient_i,
    input  logic [N_BITS_COHERENCE_MESSAGE_TYPE-1:0] in_type_i,
    input  logic [PAYLOAD_WIDTH-1:0]                 in_payload_i,
    output logic                                     query_o,
    output logic [BUS_ADDRESS_WIDTH-1:0]             query_sender_o,
    output logic [BUS_ADDRESS_WIDTH-1:0]             query_recipient_o,
    output logic [N_BITS_COHERENCE_MESSAGE_TYPE-1:0] query_transaction_type_o,
    output logic                                     delete_transaction_o,
    input  logic                                     is_a_pending_transaction_i,
    output logic                                     out_valid_o,
    input  logic                                     out_ready_i,
    output logic [BUS_ADDRESS_WIDTH-1:0]             out_sender_o,
    output logic [BUS_ADDRESS_WIDTH-1:0]             out_recipient_o,
    output logic [N_BITS_COHERENCE_MESSAGE_TYPE-1:0] out_type_o,
    output logic [PAYLOAD_WIDTH-1:0]                 out_payload_o,
    output logic                                     unexpected_reply_o,
    output logic [DROP_CNT_WIDTH-1:0]                drop_count_o
);

    state_t                         state, state_nxt;
    logic                           active;
    logic                           accept;
    logic [BUS_ADDRESS_WIDTH-1:0]   cap_sender, cap_recipient;
    msg_type_t                      cap_type;
    logic [PAYLOAD_WIDTH-1:0]       cap_payload;

    assign accept = in_valid_i && in_ready_o;

    // active keeps in_ready low until the first edge after reset release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            active        <= 1'b0;
            cap_sender    <= '0;
            cap_recipient <= '0;
            cap_type      <= '0;
            cap_payload   <= '0;
            drop_count_o  <= '0;
        end else begin
            state  <= state_nxt;
            active <= 1'b1;
            if (accept) begin
                cap_sender    <= in_sender_i;
                cap_recipient <= in_recipient_i;
                cap_type      <= in_type_i;
                cap_payload   <= in_payload_i;
            end
            if (state == ST_DROP && drop_count_o != '1) begin
                drop_count_o <= drop_count_o + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt                = state;
        in_ready_o               = 1'b0;
        query_o                  = 1'b0;
        query_sender_o           = '0;
        query_recipient_o        = '0;
        query_transaction_type_o = '0;
        delete_transaction_o     = 1'b0;
        out_valid_o              = 1'b0;
        unexpected_reply_o       = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready_o = active;
                if (in_valid_i && active) state_nxt = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                // The table is keyed from the requester's side, so sender and
                // recipient swap relative to the reply.
                query_o                  = 1'b1;
                query_sender_o           = cap_recipient;
                query_recipient_o        = cap_sender;
                query_transaction_type_o = reply2request(cap_type);
                if (is_a_pending_transaction_i) begin
                    delete_transaction_o = 1'b1;
                    state_nxt            = ST_FORWARD;
                end else begin
                    state_nxt = ST_DROP;
                end
            end
            ST_FORWARD: begin
                out_valid_o = 1'b1;
                if (out_ready_i) state_nxt = ST_IDLE;
            end
            ST_DROP: begin
                unexpected_reply_o = 1'b1;
                state_nxt          = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign out_sender_o    = cap_sender;
    assign out_recipient_o = cap_recipient;
    assign out_type_o      = cap_type;
    assign out_payload_o   = cap_payload;

endmodule

// File: tb/tb_noc2node_reply_filter.sv
// Randomized bench for noc2node_reply_filter with a transaction-level
// pending-table model and directed corner cases.
module tb_noc2node_reply_filter;
    import noc2node_reply_filter_pkg::*;

    localparam int AW = BUS_ADDRESS_WIDTH;
    localparam int TW = N_BITS_COHERENCE_MESSAGE_TYPE;
    localparam int PW = 32;
    localparam int DW = 8;
    localparam int NT = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid_i, in_ready_o;
    logic [AW-1:0] in_sender_i, in_recipient_i;
    logic [TW-1:0] in_type_i;
    logic [PW-1:0] in_payload_i;
    logic          query_o;
    logic [AW-1:0] query_sender_o, query_recipient_o;
    logic [TW-1:0] query_transaction_type_o;
    logic          delete_transaction_o;
    logic          is_a_pending_transaction_i;
    logic          out_valid_o, out_ready_i;
    logic [AW-1:0] out_sender_o, out_recipient_o;
    logic [TW-1:0] out_type_o;
    logic [PW-1:0] out_payload_o;
    logic          unexpected_reply_o;
    logic [DW-1:0] drop_count_o;

    int n_vec = 0;
    int n_err = 0;
    int exp_drops = 0;
    int n_deliv = 0;
    int n_delete = 0;
    int viol = 0;
    logic prev_q = 1'b0;
    logic prev_unexp = 1'b0;

    logic          tbl_v [NT];
    logic [AW-1:0] tbl_s [NT];
    logic [AW-1:0] tbl_r [NT];
    logic [TW-1:0] tbl_t [NT];

    noc2node_reply_filter #(.PAYLOAD_WIDTH(PW), .DROP_CNT_WIDTH(DW)) dut (
        .clk                        (clk),
        .rst                        (rst_n),
        .in_valid_i                 (in_valid_i),
        .in_ready_o                 (in_ready_o),
        .in_sender_i                (in_sender_i),
        .in_recipient_i             (in_recipient_i),
        .in_type_i                  (in_type_i),
        .in_payload_i               (in_payload_i),
        .query_o                    (query_o),
        .query_sender_o             (query_sender_o),
        .query_recipient_o          (query_recipient_o),
        .query_transaction_type_o   (query_transaction_type_o),
        .delete_transaction_o       (delete_transaction_o),
        .is_a_pending_transaction_i (is_a_pending_transaction_i),
        .out_valid_o                (out_valid_o),
        .out_ready_i                (out_ready_i),
        .out_sender_o               (out_sender_o),
        .out_recipient_o            (out_recipient_o),
        .out_type_o                 (out_type_o),
        .out_payload_o              (out_payload_o),
        .unexpected_reply_o         (unexpected_reply_o),
        .drop_count_o               (drop_count_o)
    );

    always #5 clk = ~clk;

    // Behavioural pending table answering the query combinationally
    always_comb begin
        is_a_pending_transaction_i = 1'b0;
        for (int i = 0; i < NT; i++) begin
            if (query_o && tbl_v[i] && tbl_s[i] == query_sender_o &&
                tbl_r[i] == query_recipient_o && tbl_t[i] == query_transaction_type_o)
                is_a_pending_transaction_i = 1'b1;
        end
    end

    always @(posedge clk) begin
        if (out_valid_o && out_ready_i) n_deliv <= n_deliv + 1;
        if (query_o && delete_transaction_o) n_delete <= n_delete + 1;
    end

    // Protocol invariants watched every cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (query_o && prev_q) viol <= viol + 1;
            if (!query_o && (query_sender_o != '0 || query_recipient_o != '0 ||
                             query_transaction_type_o != '0)) viol <= viol + 1;
            if (delete_transaction_o && !query_o) viol <= viol + 1;
            if (unexpected_reply_o && prev_unexp) viol <= viol + 1;
            if (in_ready_o && (query_o || out_valid_o || unexpected_reply_o)) viol <= viol + 1;
        end
        prev_q     <= query_o;
        prev_unexp <= unexpected_reply_o;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [TW-1:0] model_req(input logic [TW-1:0] t);
        return TW'(int'(t) % (1 << (TW - 1)));
    endfunction

    function automatic int find_entry(input logic [AW-1:0] s, input logic [AW-1:0] r,
                                      input logic [TW-1:0] t);
        for (int i = 0; i < NT; i++)
            if (tbl_v[i] && tbl_s[i] == s && tbl_r[i] == r && tbl_t[i] == t) return i;
        return -1;
    endfunction

    task automatic add_entry(input logic [AW-1:0] s, input logic [AW-1:0] r,
                             input logic [TW-1:0] t);
        for (int i = 0; i < NT; i++) begin
            if (!tbl_v[i]) begin
                tbl_v[i] = 1'b1; tbl_s[i] = s; tbl_r[i] = r; tbl_t[i] = t;
                return;
            end
        end
    endtask

    function automatic int sat_drops();
        return (exp_drops > 255) ? 255 : exp_drops;
    endfunction

    task automatic do_reply(input logic [AW-1:0] s, input logic [AW-1:0] r,
                            input logic [TW-1:0] t, input logic [PW-1:0] p,
                            input int stall, input bit keep_valid);
        int idx, dl0, dv0, wait_n;
        bit exp_hit;
        idx     = find_entry(r, s, model_req(t));
        exp_hit = (idx >= 0);
        @(negedge clk);
        in_sender_i = s; in_recipient_i = r; in_type_i = t; in_payload_i = p;
        in_valid_i = 1'b1; out_ready_i = 1'b0;
        wait_n = 0;
        while (!in_ready_o && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        chk("accept_timeout", 64'(wait_n < 50), 1);
        if (wait_n >= 50) begin
            in_valid_i = 1'b0;
            return;
        end
        dl0 = n_delete; dv0 = n_deliv;
        @(posedge clk); #1;
        if (!keep_valid) in_valid_i = 1'b0;
        chk("lookup_query", query_o, 1);
        chk("lookup_qsender", query_sender_o, r);
        chk("lookup_qrecipient", query_recipient_o, s);
        chk("lookup_qtype", query_transaction_type_o, model_req(t));
        chk("lookup_delete", delete_transaction_o, exp_hit);
        chk("lookup_in_ready", in_ready_o, 0);
        @(posedge clk); #1;
        if (exp_hit) begin
            tbl_v[idx] = 1'b0;
            chk("hit_delete_count", n_delete, dl0 + 1);
            for (int c = 0; c < stall; c++) begin
                chk("stall_valid", out_valid_o, 1);
                chk("stall_payload", out_payload_o, p);
                chk("stall_sender", out_sender_o, s);
                chk("stall_recipient", out_recipient_o, r);
                chk("stall_type", out_type_o, t);
                chk("stall_in_ready", in_ready_o, 0);
                @(posedge clk); #1;
            end
            chk("fwd_valid", out_valid_o, 1);
            chk("fwd_payload", out_payload_o, p);
            out_ready_i = 1'b1;
            @(posedge clk); #1;
            out_ready_i = 1'b0;
            chk("fwd_done_valid", out_valid_o, 0);
            chk("fwd_deliv_count", n_deliv, dv0 + 1);
            chk("fwd_done_in_ready", in_ready_o, 1);
        end else begin
            exp_drops++;
            chk("drop_unexpected", unexpected_reply_o, 1);
            chk("drop_out_valid", out_valid_o, 0);
            chk("drop_delete_count", n_delete, dl0);
            @(posedge clk); #1;
            chk("drop_pulse_end", unexpected_reply_o, 0);
            chk("drop_count", drop_count_o, sat_drops());
            chk("drop_no_deliv", n_deliv, dv0);
            chk("drop_in_ready", in_ready_o, 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] s, r;
        logic [TW-1:0] t, rq;
        logic [PW-1:0] p;
        int st, dv0, wait_n;

        for (int i = 0; i < NT; i++) begin
            tbl_v[i] = 1'b0; tbl_s[i] = '0; tbl_r[i] = '0; tbl_t[i] = '0;
        end
        in_valid_i = 1'b0; out_ready_i = 1'b0;
        in_sender_i = '0; in_recipient_i = '0; in_type_i = '0; in_payload_i = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready_o, 0);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_query", query_o, 0);
        chk("rst_delete", delete_transaction_o, 0);
        chk("rst_unexpected", unexpected_reply_o, 0);
        chk("rst_drop_count", drop_count_o, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", in_ready_o, 1);

        // Matched reply retires its entry; replaying it afterwards must drop
        add_entry(8'd3, 8'd5, REQ_A);
        do_reply(8'd5, 8'd3, REPLY_A, 32'hDEADBEEF, 0, 0);
        do_reply(8'd5, 8'd3, REPLY_A, 32'h12345678, 0, 0);

        // Slow master: ten cycles of back-pressure
        add_entry(8'd7, 8'd9, REQ_B);
        do_reply(8'd9, 8'd7, REPLY_B, 32'hCAFEF00D, 10, 0);

        // Back-to-back with in_valid held high
        add_entry(8'd1, 8'd2, REQ_A);
        add_entry(8'd4, 8'd6, REQ_B);
        do_reply(8'd2, 8'd1, REPLY_A, 32'h0000_0001, 0, 1);
        do_reply(8'd6, 8'd4, REPLY_B, 32'h0000_0002, 1, 1);
        do_reply(8'd6, 8'd4, REPLY_B, 32'h0000_0003, 0, 0);

        for (int k = 0; k < 40; k++) begin
            s = AW'($urandom); r = AW'($urandom); p = $urandom;
            st = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) begin
                rq = TW'($urandom_range(0, 7));
                add_entry(r, s, rq);
                t = rq + TW'(8);
            end else begin
                t = TW'($urandom);
            end
            do_reply(s, r, t, p, st, 0);
        end

        for (int k = 0; k < 260; k++) begin
            do_reply(AW'($urandom), AW'($urandom), TW'($urandom), $urandom, 0, 0);
        end
        chk("saturated_count", drop_count_o, 255);
        chk("model_saturated", 64'(exp_drops > 255), 1);

        // Reset while a matched reply waits in FORWARD
        add_entry(8'd10, 8'd11, REQ_A);
        @(negedge clk);
        in_sender_i = 8'd11; in_recipient_i = 8'd10; in_type_i = REPLY_A;
        in_payload_i = 32'hA5A5A5A5; in_valid_i = 1'b1; out_ready_i = 1'b0;
        wait_n = 0;
        while (!in_ready_o && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        chk("rstfwd_accept_timeout", 64'(wait_n < 50), 1);
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        chk("rstfwd_lookup_delete", delete_transaction_o, 1);
        @(posedge clk); #1;
        tbl_v[find_entry(8'd10, 8'd11, REQ_A) < 0 ? 0 : find_entry(8'd10, 8'd11, REQ_A)] = 1'b0;
        chk("rstfwd_in_forward", out_valid_o, 1);
        dv0 = n_deliv;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstfwd_valid_drop", out_valid_o, 0);
        chk("rstfwd_in_ready", in_ready_o, 0);
        chk("rstfwd_drop_count", drop_count_o, 0);
        exp_drops = 0;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready_i = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        out_ready_i = 1'b0;
        chk("rstfwd_no_deliv", n_deliv, dv0);
        chk("rstfwd_out_valid", out_valid_o, 0);
        chk("rstfwd_count_after", drop_count_o, 0);
        chk("rstfwd_ready_after", in_ready_o, 1);

        chk("protocol_invariants", viol, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/noc2node_reply_filter.md
NOC2NODE_REPLY_FILTER -- requirements
Module: noc2node_reply_filter

Interface
REQ-001 SHALL have parameter PAYLOAD_WIDTH, default 32, meaning reply payload bits carried to the local master.
REQ-002 SHALL have parameter DROP_CNT_WIDTH, default 8, meaning width of the unmatched-reply counter.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports in_valid_i / in_ready_o  input / output  1 / 1  NoC ingress reply handshake.
REQ-006 SHALL have port in_sender_i  input  `BUS_ADDRESS_WIDTH  remote node that produced the reply.
REQ-007 SHALL have port in_recipient_i  input  `BUS_ADDRESS_WIDTH  local master the reply targets.
REQ-008 SHALL have port in_type_i  input  `N_BITS_COHERENCE_MESSAGE_TYPE  reply message type.
REQ-009 SHALL have port in_payload_i  input  PAYLOAD_WIDTH  reply data.
REQ-010 SHALL have port query_o  output  1  drives pending-table query strobe.
REQ-011 SHALL have ports query_sender_o / query_recipient_o  output  `BUS_ADDRESS_WIDTH each  lookup key.
REQ-012 SHALL have port query_transaction_type_o  output  `N_BITS_COHERENCE_MESSAGE_TYPE  request type derived from reply type.
REQ-013 SHALL have port delete_transaction_o  output  1  retire the matched table entry.
REQ-014 SHALL have port is_a_pending_transaction_i  input  1  combinational table hit, valid same cycle as query_o.
REQ-015 SHALL have ports out_valid_o / out_ready_i  output / input  1 / 1  local-master delivery handshake.
REQ-016 SHALL have ports out_sender_o, out_recipient_o, out_type_o, out_payload_o  output  widths as inputs  delivered reply.
REQ-017 SHALL have port unexpected_reply_o  output  1  one-cycle pulse per dropped reply.
REQ-018 SHALL have port drop_count_o  output  DROP_CNT_WIDTH  saturating count of dropped replies.

Function
REQ-019 SHALL implement FSM states IDLE, LOOKUP, FORWARD, DROP.
REQ-020 IDLE: in_ready_o=1; in_valid_i&&in_ready_o captures all in_* fields into registers, next state LOOKUP.
REQ-021 in_ready_o SHALL be 0 in every state except IDLE; in_* ignored there.
REQ-022 LOOKUP: query_o=1 for exactly one cycle; query_sender_o=captured in_recipient, query_recipient_o=captured in_sender, query_transaction_type_o=reply2request(captured type).
REQ-023 LOOKUP with hit: delete_transaction_o=1 same cycle, next FORWARD; miss: delete_transaction_o=0, next DROP.
REQ-024 delete_transaction_o SHALL never be 1 outside LOOKUP nor without query_o.
REQ-025 FORWARD: out_valid_o=1, out_* = captured fields held stable until out_valid_o&&out_ready_i, then IDLE.
REQ-026 DROP: unexpected_reply_o=1 one cycle, drop_count_o increments, next IDLE.
REQ-027 drop_count_o SHALL saturate at all-ones, no wrap.
REQ-028 Minimum occupancy per reply: 3 cycles forwarded (IDLE, LOOKUP, FORWARD with out_ready_i=1), 3 cycles dropped.
REQ-029 query_* outputs SHALL be 0 whenever query_o=0.

Reset
REQ-030 On rst low, asynchronously: state IDLE, out_valid_o=0, query_o=0, delete_transaction_o=0, unexpected_reply_o=0, drop_count_o=0, captured registers 0.
REQ-031 Reset mid-LOOKUP or mid-FORWARD SHALL discard the captured reply with no delete or delivery issued.
REQ-032 in_ready_o SHALL be 0 while rst low, 1 from the first cycle after release.

Structure
REQ-033 `BUS_ADDRESS_WIDTH, `N_BITS_COHERENCE_MESSAGE_TYPE and reply/request type encodings SHALL come from NIC-defines.v.
REQ-034 reply2request SHALL be a shared function in the NIC common include, reused by the node2noc side.
REQ-035 No sub-module; pending table is instantiated by the parent and wired to the query ports.

Verification
REQ-036 Table holds (sender=3, recipient=5, type=REQ_A); reply sender=5, recipient=3, type=REPLY_A, payload 0xDEADBEEF -> LOOKUP hit, delete pulse, out_valid_o with payload 0xDEADBEEF, entry gone afterwards.
REQ-037 Reply with no matching entry -> no delete, unexpected_reply_o one pulse, drop_count_o 0->1, out_valid_o stays 0.
REQ-038 Hit with out_ready_i low 10 cycles -> out_* stable 10 cycles, in_ready_o=0 throughout, delivery on cycle ready rises.
REQ-039 256+ unmatched replies with DROP_CNT_WIDTH=8 -> drop_count_o holds 255.
REQ-040 rst asserted during FORWARD with out_ready_i=0 -> out_valid_o drops immediately, no later delivery, drop_count_o=0.
REQ-041 Back-to-back replies, in_valid_i held 1 -> second captured only after first completes; query_o never 1 two consecutive cycles.
